aes_inv_round_ctrl: RTL and testbench



---
 rtl/aes_inv_round_ctrl_if.sv | 26 ++
 rtl/aes_inv_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_round_ctrl_if.sv
// Block and round-key bus between the AES-128 decryption sequencer, the block I/O layer
// and the key schedule store.
interface aes_inv_round_ctrl_if;
    localparam int unsigned BLK_W = 128;
    localparam int unsigned IDX_W = 4;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] din;
    logic [IDX_W-1:0] rk_idx;
    logic [BLK_W-1:0] rk_data;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] dout;
    logic             busy;

    modport slave (
        input  in_valid, din, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, dout, busy
    );

    modport master (
        output in_valid, din, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, dout, busy
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption: initial AddRoundKey on accept, nine inverse rounds and a final
// round, one per clock. Defining AES_INV_CTRL_ABORT_EN adds a synchronous abort input.
module aes_inv_round_ctrl (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_INV_CTRL_ABORT_EN
    input  logic abort,
`endif
    aes_inv_round_ctrl_if.slave bus
);
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_KEY  = RND_W'(10);
    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(9);
    localparam logic [RND_W-1:0] LAST_RND  = RND_W'(1);

    // Byte 0 of the block is element [0] (bits 127:120); byte k sits at row k%4, column k/4.
    typedef logic [0:15][7:0] blk_t;
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t           state;
    blk_t             st;
    blk_t             dout_q;
    logic [RND_W-1:0] rnd;
    logic             out_valid_q;
    logic [RND_W-1:0] rk_idx_c;
    blk_t             sub_c;
    blk_t             ark_c;
    blk_t             mix_c;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4'(r + 4 * c)] = s[4'(r + 4 * ((c + 4 - r) % 4))];
        return o;
    endfunction

    function automatic blk_t inv_sub_bytes(input blk_t s);
        blk_t o;
        for (int k = 0; k < 16; k++) o[4'(k)] = inv_sbox(s[4'(k)]);
        return o;
    endfunction

    function automatic blk_t inv_mix_cols(input blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(4 * c)];
            a1 = s[4'(4 * c + 1)];
            a2 = s[4'(4 * c + 2)];
            a3 = s[4'(4 * c + 3)];
            o[4'(4 * c)]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[4'(4 * c + 1)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[4'(4 * c + 2)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[4'(4 * c + 3)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // One round of datapath; the final round uses ark_c directly, skipping InvMixColumns.
    always_comb begin
        sub_c = inv_sub_bytes(inv_shift_rows(st));
        ark_c = sub_c ^ bus.rk_data;
        mix_c = inv_mix_cols(ark_c);
    end

    // Key index follows the state: last key while waiting, the round counter while iterating.
    always_comb begin
        rk_idx_c = '0;
        case (state)
            S_IDLE:  rk_idx_c = LAST_KEY;
            S_ROUND: rk_idx_c = rnd;
            default: rk_idx_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            st          <= '0;
            dout_q      <= '0;
            rnd         <= '0;
            out_valid_q <= 1'b0;
        end else begin
`ifdef AES_INV_CTRL_ABORT_EN
            if (abort && (state != S_IDLE)) begin
                state       <= S_IDLE;
                rnd         <= '0;
                out_valid_q <= 1'b0;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            st    <= bus.din ^ bus.rk_data;
                            rnd   <= FIRST_RND;
                            state <= S_ROUND;
                        end
                    end
                    S_ROUND: begin
                        st <= mix_c;
                        if (rnd == LAST_RND) state <= S_FINAL;
                        else                 rnd   <= rnd - RND_W'(1);
                    end
                    S_FINAL: begin
                        dout_q      <= ark_c;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                    S_DONE: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.rk_idx    = rk_idx_c;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: known-answer and random vectors against a
// table-based reference decryptor, plus backpressure, back-to-back, reset and abort sequences.
module tb_aes_inv_round_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef AES_INV_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_inv_round_ctrl_if bus ();

    aes_inv_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam int NVEC = 8;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_q[$];
    logic [127:0] out_q[$];
    logic [127:0] rks [0:10];
    logic [7:0] sbox [256];
    logic [7:0] isbox [256];
    vec_t vecs [NVEC];

    // Zero-latency key store.
    always_comb bus.rk_data = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

    // Handshake monitor: accept edges and delivered blocks.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
            if (bus.out_valid && bus.out_ready) out_q.push_back(bus.dout);
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // Forward S-box by brute-force inversion, inverse S-box by table reversal.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[8'(x)]  = s;
            isbox[s]     = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [0:3][7:0] b;
        b = w;
        for (int j = 0; j < 4; j++) b[2'(j)] = sbox[b[2'(j)]];
        return b;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [0:3][31:0] kw;
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        kw = key;
        for (int i = 0; i < 4; i++) w[6'(i)] = kw[2'(i)];
        for (int i = 4; i < 44; i++) begin
            t = w[6'(i - 1)];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[6'(i)] = w[6'(i - 4)] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rks[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [0:15][7:0] s;
        logic [0:15][7:0] t;
        logic [7:0] a [4];
        s = ct ^ rks[10];
        for (int r = 9; r >= 0; r--) begin
            // Row i rotates right by i: byte in column c lands in column c+i.
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    t[4'(i + 4 * ((c + i) % 4))] = isbox[s[4'(i + 4 * c)]];
            s = t ^ rks[4'(r)];
            if (r > 0)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[2'(j)] = s[4'(4 * c + j)];
                    for (int i = 0; i < 4; i++)
                        s[4'(4 * c + i)] = mul(a[2'(i)], 8'h0e) ^ mul(a[2'((i + 1) % 4)], 8'h0b)
                                         ^ mul(a[2'((i + 2) % 4)], 8'h0d) ^ mul(a[2'((i + 3) % 4)], 8'h09);
                end
        end
        return s;
    endfunction

    // Offer a block, check the rk_idx trace and out_valid timing; returns after the valid edge.
    task automatic start_and_trace(input string tag, input logic [127:0] ct, input bit noise);
        int n = 0;
        bus.din = ct;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_accept_wait"}, 128'(n < 40), 128'd1);
        chk({tag, "_rk_idx_accept"}, 128'(bus.rk_idx), 128'd10);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("%s_rk_idx_c%0d", tag, k), 128'(bus.rk_idx), 128'(10 - k));
            chk($sformatf("%s_early_valid_c%0d", tag, k), 128'(bus.out_valid), 128'd0);
            if (noise && k <= 9) begin
                bus.in_valid = 1'(($urandom_range(0, 1)));
                bus.din = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_valid_rise"}, 128'(bus.out_valid), 128'd1);
        chk({tag, "_rk_idx_done"}, 128'(bus.rk_idx), 128'd0);
        chk({tag, "_busy_done"}, 128'(bus.busy), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.out_ready = 1'b1;
        build_sbox();
        load_key(C1_KEY);

        vecs[0] = '{C1_KEY, C1_CT, C1_PT};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        for (int i = 2; i < NVEC; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = {$urandom, $urandom, $urandom, $urandom};
            load_key(vecs[i].key);
            vecs[i].pt  = ref_decrypt(vecs[i].ct);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_dout", bus.dout, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, with in_valid/din noise during the rounds on odd entries.
        for (int i = 0; i < NVEC; i++) begin
            load_key(vecs[i].key);
            start_and_trace($sformatf("vec%0d", i), vecs[i].ct, 1'(i % 2));
            chk($sformatf("vec%0d_dout", i), bus.dout, vecs[i].pt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle", i), 128'(bus.in_ready), 128'd1);
        end

        // Backpressure: hold DONE for 20 cycles, then release for one cycle.
        load_key(C1_KEY);
        bus.out_ready = 1'b0;
        start_and_trace("bp", C1_CT, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("bp_dout_%0d", k), bus.dout, C1_PT);
            chk($sformatf("bp_in_ready_%0d", k), 128'(bus.in_ready), 128'd0);
            chk($sformatf("bp_busy_%0d", k), 128'(bus.busy), 128'd1);
            chk($sformatf("bp_valid_%0d", k), 128'(bus.out_valid), 128'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        chk("bp_release_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_release_rk_idx", 128'(bus.rk_idx), 128'd10);
        bus.out_ready = 1'b1;

        // Back-to-back with in_valid held high.
        acc_q.delete();
        out_q.delete();
        bus.din = C1_CT;
        bus.in_valid = 1'b1;
        n = 0;
        while (out_q.size() < 2 && n < 60) begin
            @(posedge clk); #1;
            if (acc_q.size() >= 2) bus.in_valid = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_done", 128'(out_q.size() >= 2 && acc_q.size() >= 2), 128'd1);
        if (acc_q.size() >= 2 && out_q.size() >= 2) begin
            chk("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd12);
            chk("b2b_dout0", out_q[0], C1_PT);
            chk("b2b_dout1", out_q[1], C1_PT);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a block.
        bus.din = C1_CT;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.rk_idx != 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach_idx5", 128'(bus.rk_idx), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_dout", bus.dout, 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_and_trace("post_rst", C1_CT, 1'b0);
        chk("post_rst_dout", bus.dout, C1_PT);
        @(posedge clk); #1;

`ifdef AES_INV_CTRL_ABORT_EN
        // Abort while iterating; no output for that block, then a clean block.
        bus.din = C1_CT;
        bus.in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_idle_ignored", 128'(bus.busy), 128'd1);
        n = 0;
        while (bus.rk_idx != 4'd3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach_idx3", 128'(bus.rk_idx), 128'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
        chk("abort_rk_idx", 128'(bus.rk_idx), 128'd10);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.out_valid) n++;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 128'(n), 128'd0);
        start_and_trace("post_abort", C1_CT, 1'b0);
        chk("post_abort_dout", bus.dout, C1_PT);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
